miner_result_ring_writer: RTL

- Sits directly downstream of the fpgaminer_top hash core inside the bitcoin AFU.
- Each golden_valid pulse from the core is captured into a small FIFO. Each captured result then becomes one posted CCI-P c1 write (WrLine_I, 1 CL) into a host-memory ring buffer.
- This replaces single-result-then-reset operation, so the miner runs continuously while results stream to the host.
- Host-side flow control uses a consumer tail index written via CSR. CCI-P flow control uses c1TxAlmFull.

---
 rtl/miner_result_ring_writer.sv | 89 ++++++++
 1 files changed

// File: rtl/miner_result_ring_writer.sv
// miner_result_ring_writer: buffers golden nonces in a FIFO and posts each as one CCI-P c1 line write into a host ring.
module miner_result_ring_writer #(
  parameter int FIFO_DEPTH   = 16,
  parameter int RING_ENTRIES = 64,
  parameter int ADDR_W       = 42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] ring_base,
  input  logic [15:0]       tail_idx,
  input  logic [31:0]       job_id,
  input  logic              golden_valid,
  input  logic [31:0]       golden_nonce,
  input  logic              c1_alm_full,
  input  logic              c1_wr_rsp_valid,
  output logic              c1_wr_valid,
  output logic [ADDR_W-1:0] c1_wr_addr,
  output logic [511:0]      c1_wr_data,
  output logic [15:0]       head_idx,
  output logic [31:0]       seq_cnt,
  output logic [15:0]       overflow_cnt,
  output logic [15:0]       outstanding,
  output logic [1:0]        state_o,
  output logic              busy
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] MASK = 16'(RING_ENTRIES - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state;
  logic [63:0] mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0] count;
  logic [ADDR_W-1:0] base;
  logic [15:0] head_nxt;
  logic ring_full, issue, push, drop, rsp_dec;
  assign head_nxt  = (head_idx + 16'd1) & MASK;
  assign ring_full = head_nxt == (tail_idx & MASK);
  assign issue     = state != IDLE && count != '0 && !c1_alm_full && !ring_full;
  assign push      = state == RUN && golden_valid && count != (FW+1)'(FIFO_DEPTH);
  assign drop      = state == RUN && golden_valid && count == (FW+1)'(FIFO_DEPTH);
  assign rsp_dec   = c1_wr_rsp_valid && outstanding != 16'd0;
  assign state_o   = state;
  assign busy      = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {job_id, golden_nonce};
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      base         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      c1_wr_valid  <= 1'b0;
      c1_wr_addr   <= '0;
      c1_wr_data   <= '0;
      head_idx     <= '0;
      seq_cnt      <= '0;
      overflow_cnt <= '0;
      outstanding  <= '0;
    end else begin
      c1_wr_valid <= issue;
      if (issue) begin
        c1_wr_addr <= base + ADDR_W'(head_idx);
        c1_wr_data <= {384'd0, 32'h600DC0DE, seq_cnt, mem[rd_ptr]};
        head_idx   <= head_nxt;
        seq_cnt    <= seq_cnt + 32'd1;
        rd_ptr     <= rd_ptr + FW'(1);
      end
      if (push) wr_ptr <= wr_ptr + FW'(1);
      count <= count + (FW+1)'(push) - (FW+1)'(issue);
      if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
      outstanding <= outstanding + 16'(issue) - 16'(rsp_dec);
      // a fresh run starts from an empty FIFO and slot 0 of a newly latched ring
      if (state == IDLE && enable) begin
        state        <= RUN;
        base         <= ring_base;
        head_idx     <= '0;
        seq_cnt      <= '0;
        overflow_cnt <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
      end else if (state == RUN && !enable) state <= DRAIN;
      else if (state == DRAIN && enable) state <= RUN;
      else if (state == DRAIN && count == '0 && outstanding == 16'd0 && !issue) state <= IDLE;
    end
  end
endmodule
